// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the RAM request/acknowledge initiator:
//   - default bus widths and WAIT timeout length
//   - FSM state encoding (IDLE, REQ, WAIT, RESP)
//   - MEM_ERR_DATA, the read data returned when a request is aborted
// -----------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int MEM_ADDR_W         = 32;
  localparam int MEM_DATA_W         = 32;
  localparam int MEM_TIMEOUT_CYCLES = 255;

  localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mem_timeout_ctr
// Counts cycles while enabled and flags the last allowed cycle.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear (takes priority over en)
//   en        : count this cycle
//   expired   : high during the LIMIT-th enabled cycle since the last clear
// -----------------------------------------------------------------------------
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of enabled cycles already completed, so the
  // LIMIT-th cycle is the one where it equals LIMIT-1.
  assign expired = en && (count_q == LAST);

endmodule

// File: rtl/mem_port_master.sv
// -----------------------------------------------------------------------------
// mem_port_master
// Initiator side of the single-outstanding RAM request/acknowledge protocol.
// Accepts one command at a time from the ALU, emits a one-cycle readReq or
// writeReq, holds address/data until the matching ack, then returns a
// one-cycle registered response.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE; the client holds its command until then.
// rsp_valid is a single-cycle pulse with no back-pressure.
//
// Optional build macro: MEM_TIMEOUT_EN
//   defined   : WAIT aborts after TIMEOUT_CYCLES cycles without a matching ack,
//               responding with rsp_err=1 and rsp_rdata=MEM_ERR_DATA. An ack in
//               the expiry cycle wins.
//   undefined : WAIT lasts until the matching ack; rsp_err is always 0.
//
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake
//   cmd_write/addr/wdata    : command type, byte address, store data
//   rsp_valid/write/rdata/err : response pulse and payload
//   busy                    : high whenever not IDLE
//   ramAddress/ramOut       : held address and write data toward the RAM
//   readReq/writeReq        : single-cycle request pulses
//   ramValue/readAck/writeAck : RAM responder returns
//   dbg_state               : current FSM state (mem_state_e encoding)
// -----------------------------------------------------------------------------
module mem_port_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramOut,
  output logic              readReq,
  output logic              writeReq,
  input  logic [DATA_W-1:0] ramValue,
  input  logic              readAck,
  input  logic              writeAck,
  output logic [1:0]        dbg_state
);

  mem_state_e state_q, state_d;

  logic              write_q,       write_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_out_q,     ram_out_d;
  logic              read_req_q,    read_req_d;
  logic              write_req_q,   write_req_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic              rsp_write_q,   rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic              rsp_err_q,     rsp_err_d;

  logic accept;
  logic ack_match;
  logic timeout_hit;

  assign accept = (state_q == ST_IDLE) && cmd_valid;

  // Only the ack of the outstanding type counts, and only while waiting;
  // acks in any other state are leftovers and are dropped.
  assign ack_match = (state_q == ST_WAIT) && (write_q ? writeAck : readAck);

`ifdef MEM_TIMEOUT_EN
  logic tmo_expired;

  // Cleared while in REQ so the count starts at zero on entry to WAIT.
  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (reset),
    .clr     (state_q == ST_REQ),
    .en      (state_q == ST_WAIT),
    .expired (tmo_expired)
  );

  assign timeout_hit = tmo_expired && !ack_match;
`else
  // Untimed build: TIMEOUT_CYCLES is accepted so both builds share one
  // parameter list, but nothing here depends on its value.
  if (TIMEOUT_CYCLES >= 0) begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)                   state_d = ST_REQ;
      ST_REQ:                                state_d = ST_WAIT;
      ST_WAIT: if (ack_match || timeout_hit) state_d = ST_RESP;
      ST_RESP:                               state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Next values for every registered output. Request and response strobes
  // default low so each is a single-cycle pulse.
  always_comb begin
    write_d       = write_q;
    ram_address_d = ram_address_q;
    ram_out_d     = ram_out_q;
    read_req_d    = 1'b0;
    write_req_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_write_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d       = cmd_write;
          ram_address_d = cmd_addr;
          ram_out_d     = cmd_wdata;
          read_req_d    = !cmd_write;
          write_req_d   = cmd_write;
        end
      end
      ST_WAIT: begin
        if (ack_match) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = write_q ? '0 : ramValue;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = DATA_W'(MEM_ERR_DATA);
          rsp_err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q       <= 1'b0;
      ram_address_q <= '0;
      ram_out_q     <= '0;
      read_req_q    <= 1'b0;
      write_req_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      write_q       <= write_d;
      ram_address_q <= ram_address_d;
      ram_out_q     <= ram_out_d;
      read_req_q    <= read_req_d;
      write_req_q   <= write_req_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;
  assign ramAddress = ram_address_q;
  assign ramOut     = ram_out_q;
  assign readReq    = read_req_q;
  assign writeReq   = write_req_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mem_port_master.sv
// -----------------------------------------------------------------------------
// tb_mem_port_master
// Directed bench for mem_port_master. Inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge. A small memory model
// stands in for the RAM responder's storage.
// -----------------------------------------------------------------------------
module tb_mem_port_master;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TMO = 8;
`else
  localparam int TB_TMO = 255;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic [31:0] ramValue;
  logic        readAck;
  logic        writeAck;
  logic [1:0]  dbg_state;

  int pass_cnt;
  int chk_cnt;
  int req_pulses;
  int both_req;

  logic [31:0] model_mem [logic [31:0]];

  mem_port_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .ramAddress (ramAddress),
    .ramOut     (ramOut),
    .readReq    (readReq),
    .writeReq   (writeReq),
    .ramValue   (ramValue),
    .readAck    (readAck),
    .writeAck   (writeAck),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each cycle with a req line high is one responder access.
  always @(posedge clk) begin
    if (readReq || writeReq) req_pulses++;
    if (readReq && writeReq) both_req++;
  end

  // -------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------- driver
  // Full transaction against a responder that acks ack_gap cycles after the
  // req pulse ends (ack_gap=1 is minimum latency). Called and returns on a
  // falling edge with the DUT idle.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_gap, output logic [31:0] rdata,
                         output logic rwr, output logic rerr);
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", (n < 50), 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("req_pulse", {readReq, writeReq}, wr ? 2'b01 : 2'b10);
    check("addr_capture", ramAddress, addr);
    @(negedge clk);
    check("req_drop", {readReq, writeReq}, 2'b00);
    repeat (ack_gap) begin
      @(negedge clk);
      check("wait_addr_stable", ramAddress, addr);
      check("wait_data_stable", ramOut, wdata);
      check("wait_no_rsp", rsp_valid, 1'b0);
    end
    if (wr) begin
      model_mem[ramAddress] = ramOut;
      writeAck = 1'b1;
    end else begin
      ramValue = model_mem.exists(ramAddress) ? model_mem[ramAddress] : 32'h0;
      readAck  = 1'b1;
    end
    @(negedge clk);
    readAck  = 1'b0;
    writeAck = 1'b0;
    ramValue = 32'h0;
    check("rsp_valid", rsp_valid, 1'b1);
    rdata = rsp_rdata;
    rwr   = rsp_write;
    rerr  = rsp_err;
    @(negedge clk);
    check("rsp_pulse_end", rsp_valid, 1'b0);
    check("ready_return", cmd_ready, 1'b1);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] rd;
    logic        rw;
    logic        re;
    int          p0;

    pass_cnt   = 0;
    chk_cnt    = 0;
    req_pulses = 0;
    both_req   = 0;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 32'h0;
    cmd_wdata  = 32'h0;
    ramValue   = 32'h0;
    readAck    = 1'b0;
    writeAck   = 1'b0;
    model_mem[32'h10] = 32'h12345678;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_reqs", {readReq, writeReq}, 2'b00);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_err}, 3'b000);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_addr", ramAddress, 32'h0);
    check("rst_out", ramOut, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single read, minimum latency
    p0 = req_pulses;
    run_txn(1'b0, 32'h10, 32'h0, 1, rd, rw, re);
    check("read_rdata", rd, 32'h12345678);
    check("read_rsp_write", rw, 1'b0);
    check("read_rsp_err", re, 1'b0);
    check("read_one_access", req_pulses - p0, 1);

    // Write, slower ack, then read it back
    run_txn(1'b1, 32'h20, 32'hCAFEF00D, 3, rd, rw, re);
    check("write_rdata", rd, 32'h0);
    check("write_rsp_write", rw, 1'b1);
    check("write_rsp_err", re, 1'b0);
    check("write_stored", model_mem.exists(32'h20) ? model_mem[32'h20] : 32'h0, 32'hCAFEF00D);
    run_txn(1'b0, 32'h20, 32'h0, 1, rd, rw, re);
    check("readback", rd, 32'hCAFEF00D);
    @(negedge clk);
    check("rdata_hold", rsp_rdata, 32'hCAFEF00D);

    // Back-to-back reads with cmd_valid held
    p0 = req_pulses;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_req", readReq, 1'b1);
      check("b2b_addr", ramAddress, 32'(i * 4));
      if (i == 3) cmd_valid = 1'b0;
      else cmd_addr = 32'((i + 1) * 4);
      @(negedge clk);
      check("b2b_req_drop", readReq, 1'b0);
      check("b2b_addr_held", ramAddress, 32'(i * 4));
      @(negedge clk);
      readAck  = 1'b1;
      ramValue = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      readAck  = 1'b0;
      ramValue = 32'h0;
      check("b2b_rsp", rsp_valid, 1'b1);
      check("b2b_rdata", rsp_rdata, 32'hA000_0000 + 32'(i));
      check("b2b_not_ready", cmd_ready, 1'b0);
      @(negedge clk);
      check("b2b_ready", cmd_ready, 1'b1);
    end
    @(negedge clk);
    check("b2b_accesses", req_pulses - p0, 4);
    check("b2b_idle", busy, 1'b0);

    // Stray acks: readAck in IDLE, readAck in REQ, writeAck in read WAIT
    readAck = 1'b1;
    @(negedge clk);
    readAck = 1'b0;
    check("stray_idle_ready", cmd_ready, 1'b1);
    check("stray_idle_rsp", rsp_valid, 1'b0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h30;
    @(negedge clk);
    cmd_valid = 1'b0;
    readAck   = 1'b1;
    @(negedge clk);
    readAck  = 1'b0;
    writeAck = 1'b1;
    check("stray_req_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    writeAck = 1'b0;
    check("stray_wait_rsp", rsp_valid, 1'b0);
    check("stray_wait_busy", busy, 1'b1);
    @(negedge clk);
    check("stray_still_wait", {busy, rsp_valid}, 2'b10);
    readAck  = 1'b1;
    ramValue = 32'h0BADF00D;
    @(negedge clk);
    readAck  = 1'b0;
    ramValue = 32'h0;
    check("stray_real_rsp", rsp_valid, 1'b1);
    check("stray_real_rdata", rsp_rdata, 32'h0BADF00D);
    @(negedge clk);

    // Reset three cycles after readReq
    cmd_valid = 1'b1;
    cmd_addr  = 32'h40;
    cmd_wdata = 32'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstw_req", readReq, 1'b1);
    repeat (3) @(negedge clk);
    check("rstw_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("rstw_busy", busy, 1'b0);
    check("rstw_ready", cmd_ready, 1'b1);
    check("rstw_addr", ramAddress, 32'h0);
    check("rstw_out", ramOut, 32'h0);
    check("rstw_rdata", rsp_rdata, 32'h0);
    check("rstw_reqs", {readReq, writeReq}, 2'b00);
    @(negedge clk);
    reset    = 1'b0;
    readAck  = 1'b1;
    ramValue = 32'h55;
    @(negedge clk);
    readAck  = 1'b0;
    ramValue = 32'h0;
    check("rstw_late_ack_rsp", rsp_valid, 1'b0);
    check("rstw_late_ack_busy", busy, 1'b0);
    run_txn(1'b0, 32'h10, 32'h0, 1, rd, rw, re);
    check("rstw_next_rdata", rd, 32'h12345678);

`ifdef MEM_TIMEOUT_EN
    // No ack: eight WAIT cycles, then an error response
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h50;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("tmo_no_rsp_yet", rsp_valid, 1'b0);
    end
    @(negedge clk);
    check("tmo_rsp", rsp_valid, 1'b1);
    check("tmo_err", rsp_err, 1'b1);
    check("tmo_rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    // Ack during the expiry cycle wins
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    readAck  = 1'b1;
    ramValue = 32'h600D600D;
    @(negedge clk);
    readAck  = 1'b0;
    ramValue = 32'h0;
    check("tmo_ack_rsp", rsp_valid, 1'b1);
    check("tmo_ack_err", rsp_err, 1'b0);
    check("tmo_ack_rdata", rsp_rdata, 32'h600D600D);
    @(negedge clk);
`endif

    check("never_both_reqs", both_req, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Synthesizable initiator side of the CPU's single-outstanding RAM request/acknowledge protocol (readReq/writeReq out; readAck/writeAck and ramValue in).
- Sits between the ALU's fetch/load/store logic (simple valid/ready command, registered response) and the memory responder.
- Owns the request pulse, address/data hold and ack matching, so the ALU never talks to the RAM port directly.

Parameters:
- ADDR_W, 32, width of cmd_addr / ramAddress.
- DATA_W, 32, width of write data, ramOut, ramValue and rsp_rdata.
- TIMEOUT_CYCLES, 255, number of WAIT cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  client has a command.
- cmd_ready  out  1  master can accept (high only in IDLE).
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_write  out  1  echoes the completed command type.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_err  out  1  timeout abort flag (0 without MEM_TIMEOUT_EN).
- busy  out  1  high in every state except IDLE.
- ramAddress  out  ADDR_W  held address.
- ramOut  out  DATA_W  held write data.
- readReq  out  1  one-cycle read request pulse.
- writeReq  out  1  one-cycle write request pulse.
- ramValue  in  DATA_W  read data, valid in the readAck cycle.
- readAck  in  1  read-complete pulse.
- writeAck  in  1  write-complete pulse.

Behaviour:
- Reset values: state=IDLE; cmd_ready=1; all other outputs 0, including ramAddress, ramOut, rsp_rdata and the reqs.
- All outputs are registered except cmd_ready and busy, which decode from the state register.
- IDLE: on cmd_valid&&cmd_ready, capture cmd_write, cmd_addr and cmd_wdata into ramAddress/ramOut. Next state REQ.
- REQ: exactly one of readReq/writeReq high for exactly one cycle. Never both.
  - The request must be a single-cycle pulse. The responder re-samples the req lines the cycle after it acks, so a held req would cause a duplicate access.
  - Next state WAIT.
- WAIT:
  - ramAddress/ramOut stay stable.
  - Matching ack (readAck for a read, writeAck for a write) moves to RESP. For a read, ramValue is latched into rsp_rdata.
  - A non-matching ack is ignored.
- RESP: rsp_valid=1 for one cycle, with rsp_write/rsp_rdata/rsp_err valid. Next state IDLE.
  - rsp_rdata holds its value until the next capture.
- Latency:
  - Command accepted at edge N; req high N..N+1.
  - A minimum-latency responder acks at N+2; rsp_valid is high N+3..N+4.
  - cmd_ready returns at N+4.
- Acks arriving in IDLE, REQ or RESP are stale and ignored.
- Reset mid-operation: return to IDLE immediately and drop req lines. An ack arriving after reset is ignored.
- cmd_valid while busy: not accepted (cmd_ready=0). The client must hold the command.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter clears on entry to WAIT.
  - When the count reaches TIMEOUT_CYCLES with no matching ack, go to RESP with rsp_err=1 and rsp_rdata=32'hDEADBEEF.
  - An ack arriving in the same cycle as expiry wins: normal response, rsp_err=0.
- Undefined: no counter, WAIT lasts indefinitely, rsp_err tied to 0.

Decomposition:
- Package mem_bus_pkg:
  - state encoding (IDLE, REQ, WAIT, RESP).
  - constant MEM_ERR_DATA = 32'hDEADBEEF.
  - default widths.
- One sub-module, mem_timeout_ctr, provides the clear/enable/expired counter. It is instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Read: cmd_write=0, cmd_addr=0x10, responder returns 0x12345678 -> readReq high exactly 1 cycle; rsp_valid at cmd+3; rsp_rdata=0x12345678; rsp_err=0.
- Write: cmd_addr=0x20, cmd_wdata=0xCAFEF00D -> writeReq 1-cycle pulse; ramOut stable until writeAck; rsp_write=1; rsp_rdata=0. Readback of 0x20 returns 0xCAFEF00D.
- Back-to-back: 4 reads of 0x0/0x4/0x8/0xC with cmd_valid held -> each accepted only when cmd_ready=1; exactly 4 req pulses; no duplicate responder accesses.
- Stray ack: writeAck pulsed during a read WAIT, and readAck pulsed in IDLE -> no state change, no rsp_valid. The later real readAck completes normally.
- Reset mid-WAIT: assert reset 3 cycles after readReq -> outputs return to reset values asynchronously; a subsequent readAck is ignored; the next command works.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ack -> rsp_valid after 8 WAIT cycles with rsp_err=1 and rsp_rdata=0xDEADBEEF. Ack on the expiry cycle gives rsp_err=0.
